// File: rtl/text_console_pkg.sv
// Shared constants and types for the text console writer.
package text_console_pkg;

    // Default geometry: 800x600 screen with an 8x12 glyph cell.
    localparam int COLS_DEF        = 100;
    localparam int ROWS_DEF        = 50;
    localparam int SCREEN_BASE_DEF = 1024;   // glyph table lives below this
    localparam int TAB_WIDTH_DEF   = 8;
    localparam logic [7:0] BLANK_CHAR_DEF = 8'h20;

    // Control codes the engine interprets; every other code below 0x20 is dropped.
    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_TAB = 8'h09;
    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_CR  = 8'h0D;

    // IDLE accepts characters; CLEAR streams blank writes over a cell range.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Cursor operations applied at the clock edge.
    typedef enum logic [2:0] {
        CUR_NOP     = 3'd0,
        CUR_ADVANCE = 3'd1,
        CUR_NEWLINE = 3'd2,
        CUR_HOME    = 3'd3,
        CUR_BACK    = 3'd4,
        CUR_TAB     = 3'd5,
        CUR_CR      = 3'd6
    } cur_op_e;

endpackage

// File: rtl/text_cursor.sv
// Cursor state: column, row and the row's cell offset (row*COLS kept
// incrementally so no multiplier is needed). The screen wraps, never scrolls.
module text_cursor
    import text_console_pkg::*;
#(
    parameter int COLS      = COLS_DEF,
    parameter int ROWS      = ROWS_DEF,
    parameter int TAB_WIDTH = TAB_WIDTH_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  cur_op_e     i_op,
    output logic [6:0]  o_col,
    output logic [5:0]  o_row,
    output logic [12:0] o_row_base,
    output logic [12:0] o_nl_row_base,  // row_base the next newline will land on
    output logic        o_at_last_col,
    output logic        o_tab_wraps     // a TAB now would run off the row
);

    localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
    localparam logic [5:0]  ROW_LAST = 6'(ROWS - 1);
    localparam logic [12:0] ROW_STEP = 13'(COLS);

    logic [6:0]  r_col;
    logic [5:0]  r_row;
    logic [12:0] r_row_base;

    logic [7:0]  w_tab_col;
    logic [5:0]  w_nl_row;
    logic        w_do_nl;

    // One extra bit so the tab stop past the last column cannot alias.
    assign w_tab_col     = ({1'b0, r_col} | 8'(TAB_WIDTH - 1)) + 8'd1;
    assign o_tab_wraps   = (w_tab_col >= 8'(COLS));
    assign o_at_last_col = (r_col == COL_LAST);
    assign w_nl_row      = (r_row == ROW_LAST) ? '0 : r_row + 6'd1;
    assign o_nl_row_base = (r_row == ROW_LAST) ? '0 : r_row_base + ROW_STEP;

    // Advance past the last column and tab overflow both collapse into newline.
    assign w_do_nl = (i_op == CUR_NEWLINE) ||
                     (i_op == CUR_ADVANCE && o_at_last_col) ||
                     (i_op == CUR_TAB && o_tab_wraps);

    // Apply the requested cursor operation.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else if (w_do_nl) begin
            r_col      <= '0;
            r_row      <= w_nl_row;
            r_row_base <= o_nl_row_base;
        end else begin
            unique case (i_op)
                CUR_ADVANCE: r_col <= r_col + 7'd1;
                CUR_HOME: begin
                    r_col      <= '0;
                    r_row      <= '0;
                    r_row_base <= '0;
                end
                CUR_BACK:    if (r_col != '0) r_col <= r_col - 7'd1;
                CUR_TAB:     r_col <= w_tab_col[6:0];
                CUR_CR:      r_col <= '0;
                default:     ;
            endcase
        end
    end

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_row_base = r_row_base;

endmodule

// File: rtl/text_console_writer.sv
// Character-stream terminal engine driving the video controller's CPU write
// port. Accepts one code per cycle, keeps a cursor, and emits screen-cell
// writes for glyphs, backspace blanks and row/screen clears.
module text_console_writer
    import text_console_pkg::*;
#(
    parameter int         COLS        = COLS_DEF,
    parameter int         ROWS        = ROWS_DEF,
    parameter int         SCREEN_BASE = SCREEN_BASE_DEF,
    parameter logic [7:0] BLANK_CHAR  = BLANK_CHAR_DEF,
    parameter int         TAB_WIDTH   = TAB_WIDTH_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,      // asynchronous, active low
    input  logic        i_char_valid,
    input  logic [7:0]  i_char_data,
    output logic        o_char_ready,
    output logic        o_vid_write,
    output logic [12:0] o_vid_addr,
    output logic [15:0] o_vid_value,
    output logic [6:0]  o_cursor_x,
    output logic [5:0]  o_cursor_y,
    output logic        o_busy
);

    localparam logic [12:0] BASE      = 13'(SCREEN_BASE);
    localparam logic [12:0] LAST_CELL = 13'(COLS * ROWS - 1);
    localparam logic [12:0] ROW_SPAN  = 13'(COLS - 1);

    state_e      r_state;
    logic [12:0] r_clr_addr;   // next cell offset to blank
    logic [12:0] r_clr_end;    // last cell offset to blank, inclusive
    logic        r_clr_last;   // final blank already issued
    logic        r_vid_write;
    logic [12:0] r_vid_addr;
    logic [15:0] r_vid_value;
    logic        r_char_ready;
    logic        r_busy;

    logic [6:0]  w_col;
    logic [5:0]  w_row;
    logic [12:0] w_row_base;
    logic [12:0] w_nl_row_base;
    logic        w_at_last_col;
    logic        w_tab_wraps;

    logic        w_accept;
    logic        w_printable;
    cur_op_e     w_cur_op;
    logic        w_wr;         // write issued on this acceptance
    logic [12:0] w_wr_off;
    logic [7:0]  w_wr_char;
    logic        w_clr_go;     // acceptance starts a clear
    logic        w_clr_now;    // first blank goes out with the acceptance itself
    logic [12:0] w_clr_start;
    logic [12:0] w_clr_end;

    assign w_accept    = i_char_valid && r_char_ready;
    assign w_printable = (i_char_data >= 8'h20);

    text_cursor #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .TAB_WIDTH (TAB_WIDTH)
    ) u_cursor (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_op          (w_cur_op),
        .o_col         (w_col),
        .o_row         (w_row),
        .o_row_base    (w_row_base),
        .o_nl_row_base (w_nl_row_base),
        .o_at_last_col (w_at_last_col),
        .o_tab_wraps   (w_tab_wraps)
    );

    // Decode an accepted code into a cursor op, an optional write and an optional clear.
    always_comb begin
        w_cur_op    = CUR_NOP;
        w_wr        = 1'b0;
        w_wr_off    = w_row_base + 13'(w_col);
        w_wr_char   = BLANK_CHAR;
        w_clr_go    = 1'b0;
        w_clr_now   = 1'b0;
        w_clr_start = w_nl_row_base;
        w_clr_end   = w_nl_row_base + ROW_SPAN;
        if (w_accept) begin
            if (w_printable) begin
                w_cur_op  = CUR_ADVANCE;
                w_wr      = 1'b1;
                w_wr_char = i_char_data;
                // Glyph write owns this cycle; the row clear follows it.
                w_clr_go  = w_at_last_col;
            end else begin
                unique case (i_char_data)
                    CC_CR: w_cur_op = CUR_CR;
                    CC_LF: begin
                        w_cur_op  = CUR_NEWLINE;
                        w_clr_go  = 1'b1;
                        w_clr_now = 1'b1;
                    end
                    CC_BS: begin
                        w_cur_op = CUR_BACK;
                        if (w_col != '0) begin
                            w_wr     = 1'b1;
                            w_wr_off = w_row_base + 13'(w_col) - 13'd1;
                        end
                    end
                    CC_TAB: begin
                        w_cur_op  = CUR_TAB;
                        w_clr_go  = w_tab_wraps;
                        w_clr_now = w_tab_wraps;
                    end
                    CC_FF: begin
                        w_cur_op    = CUR_HOME;
                        w_clr_go    = 1'b1;
                        w_clr_now   = 1'b1;
                        w_clr_start = '0;
                        w_clr_end   = LAST_CELL;
                    end
                    default: ;
                endcase
                if (w_clr_now) begin
                    w_wr     = 1'b1;
                    w_wr_off = w_clr_start;
                end
            end
        end
    end

    // Control FSM, clear counter and registered write port.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= CLEAR;
            r_clr_addr   <= '0;
            r_clr_end    <= LAST_CELL;
            r_clr_last   <= 1'b0;
            r_vid_write  <= 1'b0;
            r_vid_addr   <= '0;
            r_vid_value  <= '0;
            r_char_ready <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            r_vid_write <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_wr) begin
                        r_vid_write <= 1'b1;
                        r_vid_addr  <= BASE + w_wr_off;
                        r_vid_value <= {8'h00, w_wr_char};
                    end
                    if (w_clr_go) begin
                        r_state      <= CLEAR;
                        r_clr_addr   <= w_clr_now ? w_clr_start + 13'd1 : w_clr_start;
                        r_clr_end    <= w_clr_end;
                        r_clr_last   <= w_clr_now && (w_clr_start == w_clr_end);
                        r_char_ready <= 1'b0;
                        r_busy       <= 1'b1;
                    end else begin
                        r_char_ready <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (r_clr_last) begin
                        // Ready one cycle after the final blank write.
                        r_state      <= IDLE;
                        r_char_ready <= 1'b1;
                        r_busy       <= 1'b0;
                    end else begin
                        r_vid_write <= 1'b1;
                        r_vid_addr  <= BASE + r_clr_addr;
                        r_vid_value <= {8'h00, BLANK_CHAR};
                        r_clr_addr  <= r_clr_addr + 13'd1;
                        r_clr_last  <= (r_clr_addr == r_clr_end);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_vid_write  = r_vid_write;
    assign o_vid_addr   = r_vid_addr;
    assign o_vid_value  = r_vid_value;
    assign o_char_ready = r_char_ready;
    assign o_busy       = r_busy;
    assign o_cursor_x   = w_col;
    assign o_cursor_y   = w_row;

endmodule

// File: tb/tb_text_console_writer.sv
// Scoreboard bench: expected screen writes are queued as characters are sent
// and compared in order as the engine emits them.
module tb_text_console_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic        char_ready, vid_write, busy;
    logic [12:0] vid_addr;
    logic [15:0] vid_value;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;

    typedef struct packed {
        logic [12:0] a;
        logic [15:0] v;
    } wr_t;

    wr_t q[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  n_pop = 0;

    always #5 clk = ~clk;

    text_console_writer dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_char_valid (char_valid),
        .i_char_data  (char_data),
        .o_char_ready (char_ready),
        .o_vid_write  (vid_write),
        .o_vid_addr   (vid_addr),
        .o_vid_value  (vid_value),
        .o_cursor_x   (cursor_x),
        .o_cursor_y   (cursor_y),
        .o_busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                         tag, obs, obs, exp, exp, $time);
        end
    endtask

    task automatic push(input int addr, input logic [7:0] ch);
        wr_t e;
        e.a = 13'(addr);
        e.v = {8'h00, ch};
        q.push_back(e);
    endtask

    // Blank writes for a whole row.
    task automatic push_row(input int row);
        for (int i = 0; i < 100; i++) push(1024 + row * 100 + i, 8'h20);
    endtask

    // Write monitor: pop and compare every strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy_vs_ready", busy, !char_ready);
            if (vid_write) begin
                if (q.size() == 0) begin
                    chk("unexpected_write_addr", vid_addr, 0);
                    chk("unexpected_write", 1, 0);
                end else begin
                    wr_t e;
                    e = q.pop_front();
                    chk("wr_addr", vid_addr, e.a);
                    chk("wr_value", vid_value, e.v);
                    n_pop++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] c);
        int w;
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = c;
        w = 0;
        while (!char_ready && w < 20000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20000) begin
            chk("send_timeout", 0, 1);
            char_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 char_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        do begin
            @(negedge clk);
            #1;
            w++;
        end while (!(q.size() == 0 && char_ready) && w < 20000);
        if (w >= 20000) chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int cyc, wr, lowc, base;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_vid_write", vid_write, 0);
        chk("rst_vid_addr", vid_addr, 0);
        chk("rst_vid_value", vid_value, 0);
        chk("rst_cursor_x", cursor_x, 0);
        chk("rst_cursor_y", cursor_y, 0);
        chk("rst_ready", char_ready, 0);
        chk("rst_busy", busy, 1);

        // Power-up clear: 5000 consecutive blanks, ready the cycle after 6023.
        for (int i = 0; i < 5000; i++) push(1024 + i, 8'h20);
        rst_n = 1'b1;
        cyc = 0;
        wr  = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (vid_write) wr++;
        end while (!(vid_write && vid_addr == 13'd6023) && cyc < 6000);
        chk("init_cycles", cyc, 5000);
        chk("init_writes", wr, 5000);
        chk("init_ready_at_last", char_ready, 0);
        @(negedge clk);
        chk("init_ready_after", char_ready, 1);
        chk("init_write_after", vid_write, 0);
        drain();

        // Back-to-back glyphs.
        push(1024, 8'h41);
        push(1025, 8'h42);
        send(8'h41);
        send(8'h42);
        @(negedge clk);
        chk("ab_cursor_x", cursor_x, 2);
        chk("ab_ready", char_ready, 1);

        // CR returns to column 0 without writing.
        send(8'h0D);
        @(negedge clk);
        chk("cr_cursor_x", cursor_x, 0);
        chk("cr_cursor_y", cursor_y, 0);

        // Full row of glyphs wraps into a row clear of row 1.
        for (int i = 0; i < 100; i++) push(1024 + i, 8'h78);
        push_row(1);
        for (int i = 0; i < 100; i++) send(8'h78);
        drain();
        chk("wrap_cursor_x", cursor_x, 0);
        chk("wrap_cursor_y", cursor_y, 1);

        // Walk to row 49, then column 5.
        for (int r = 2; r < 50; r++) begin
            push_row(r);
            send(8'h0A);
        end
        for (int i = 0; i < 5; i++) push(1024 + 4900 + i, 8'h79);
        for (int i = 0; i < 5; i++) send(8'h79);
        drain();
        chk("pre_lf_x", cursor_x, 5);
        chk("pre_lf_y", cursor_y, 49);

        // LF on the last row wraps to row 0; ready low for exactly 100 cycles.
        push_row(0);
        send(8'h0A);
        lowc = 0;
        begin
            int w;
            w = 0;
            forever begin
                @(negedge clk);
                w++;
                if (char_ready || w > 500) break;
                lowc++;
            end
        end
        chk("lf_ready_low", lowc, 100);
        drain();
        chk("lf_wrap_x", cursor_x, 0);
        chk("lf_wrap_y", cursor_y, 0);

        // TAB and BS around column 3.
        push(1024, 8'h61);
        push(1025, 8'h62);
        push(1026, 8'h63);
        send(8'h61);
        send(8'h62);
        send(8'h63);
        send(8'h09);
        @(negedge clk);
        chk("tab_col", cursor_x, 8);
        push(1024 + 7, 8'h20);
        send(8'h08);
        drain();
        chk("bs_col", cursor_x, 7);
        send(8'h0D);
        send(8'h08);
        send(8'h01);
        repeat (3) @(negedge clk);
        #1;
        chk("bs0_no_write", q.size(), 0);
        chk("bs0_col", cursor_x, 0);
        chk("bs0_row", cursor_y, 0);

        // FF mid-line, then reset during the clear.
        push(1024, 8'h71);
        send(8'h71);
        drain();
        chk("q_col", cursor_x, 1);
        for (int i = 0; i < 5000; i++) push(1024 + i, 8'h20);
        base = n_pop;
        send(8'h0C);
        @(negedge clk);
        chk("ff_cursor_x", cursor_x, 0);
        chk("ff_busy", busy, 1);
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (n_pop - base < 2000 && cyc < 6000);
        chk("ff_progress", n_pop - base, 2000);
        rst_n = 1'b0;
        #1;
        chk("abort_write", vid_write, 0);
        chk("abort_cursor_x", cursor_x, 0);
        chk("abort_ready", char_ready, 0);
        q.delete();
        for (int i = 0; i < 5000; i++) push(1024 + i, 8'h20);
        @(negedge clk);
        rst_n = 1'b1;
        drain();
        chk("final_cursor_x", cursor_x, 0);
        chk("final_cursor_y", cursor_y, 0);
        chk("final_ready", char_ready, 1);
        chk("final_q_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
